riscv_run_controller: RTL and testbench
=======================================

// Module: riscv_run_controller
// PURPOSE
//   Synthesizable run/check controller for the pipelined RISC-V core.
//   - Sequences core reset and run.
//   - Detects program halt: a self-loop "j ." leaves PC stable.
//   - Enforces a cycle watchdog.
//   - Reads back NUM_CHK architectural registers over a debug read port.
//   - Compares each against its expected value and reports pass/fail.
//   Sits between the bench/host and the core; replaces fixed-length clocking with a parametrised, self-checking run.
// PARAMETERS
//   DATA_W      32   register/PC width
//   REG_AW      5    register address width
//   NUM_CHK     2    number of register checks (>=1)
//   CYC_W       16   cycle counter width; MAX_CYCLES must be < 2**CYC_W
//   MAX_CYCLES  200  watchdog: run cycles before timeout
//   RST_CYCLES  1    cycles core_rst held high after start (>=1)
//   HALT_STABLE 4    consecutive cycles with unchanged pc_in that count as a halt (>=2)
// PORTS
//   clk         in   1                clock, rising edge
//   rst         in   1                asynchronous, active-low reset
//   start       in   1                1-cycle pulse; begins a run (honoured in IDLE/DONE only)
//   core_rst    out  1                active-high reset to core
//   core_run    out  1                high while in RUN
//   pc_in       in   DATA_W           core fetch PC
//   dbg_raddr   out  REG_AW           register-file debug read address
//   dbg_rdata   in   DATA_W           debug read data; valid 1 cycle after dbg_raddr
//   exp_addr    in   NUM_CHK*REG_AW   check i address = exp_addr[i*REG_AW +: REG_AW]
//   exp_data    in   NUM_CHK*DATA_W   check i expected value, same slicing
//   done        out  1                run finished, held until next start
//   pass        out  1                all checks matched (valid when done)
//   timeout     out  1                watchdog expired (valid when done)
//   fail_idx    out  clog2(NUM_CHK)  index of first mismatching check (1 bit when NUM_CHK=1)
//   cycle_count out  CYC_W            RUN cycles elapsed, frozen after RUN
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE.
//   - Outputs: core_rst=1, core_run=0, dbg_raddr=0, done=0, pass=0, timeout=0, fail_idx=0, cycle_count=0.
//   - Reset mid-run aborts everything; no partial result is retained.
// - FSM: IDLE -> RESET -> RUN -> CHECK -> DONE.
// - IDLE: core_rst=1. On start: go to RESET; clear done/pass/timeout/fail_idx/cycle_count.
// - RESET: core_rst=1 for exactly RST_CYCLES cycles, then RUN.
// - RUN:
//   - Outputs: core_rst=0, core_run=1. cycle_count +1 per cycle, saturating.
//   - last_pc is registered each cycle; stab counts consecutive cycles with pc_in==last_pc.
//   - stab resets to 0 on any PC change and on RUN entry.
//   - stab reaching HALT_STABLE-1: halt -> CHECK.
//   - cycle_count reaching MAX_CYCLES-1 without a halt:
//     - go to DONE with timeout=1, pass=0.
//     - Halt and timeout in the same cycle: halt wins, no timeout.
// - CHECK: core_run=0, core_rst stays 0 so the register file is preserved. Pipelined reads:
//   - Cycle k: dbg_raddr=exp_addr[k].
//   - Cycle k+1: compare dbg_rdata with exp_data[k].
//   - First mismatch: fail_idx=k, pass=0, go to DONE immediately.
//   - All match: pass=1, DONE after NUM_CHK+1 cycles.
//   - Address 0 checks are legal; x0 is expected to read 0.
// - DONE: done=1. pass/timeout/fail_idx/cycle_count held; core_rst=0.
//   - start returns to RESET and clears the flags in the same edge.
// - start during RESET/RUN/CHECK is ignored.
// - All outputs are registered; no combinational input-to-output paths.
// TESTING
// 1. Fibonacci program that halts at "j .", x10 expected 55, x0 expected 0:
//    done=1, pass=1, timeout=0, cycle_count < MAX_CYCLES.
// 2. Even/odd series, x28=3, x21=10: checks on x8/x9 against the golden counts give pass=1.
//    A corrupted exp_data[1] gives pass=0, fail_idx=1.
// 3. Program that never halts (PC always changes), MAX_CYCLES=50:
//    done=1 with timeout=1, pass=0, cycle_count=49.
// 4. Halt detected exactly at cycle MAX_CYCLES-1: timeout=0, CHECK is entered.
// 5. Drop rst mid-RUN and mid-CHECK: outputs return to reset values at once and core_rst=1.
//    A fresh start then completes normally.
// 6. start pulses during RUN are ignored (cycle_count is unaffected).
//    start in DONE reruns with RST_CYCLES=3: core_rst is high for exactly 3 cycles.

Source files
------------

// File: rtl/riscv_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_run_controller
//  Description : Run/check controller for the pipelined RISC-V core. It holds
//                the core in reset, releases it to run, detects a halt
//                (a "j ." self-loop that leaves the PC stable), enforces a
//                cycle watchdog, then reads back NUM_CHK architectural
//                registers over the debug port and reports pass/fail.
//  Ports       : clk_i, rst_ni         clock, asynchronous active-low reset
//                start_i               1-cycle pulse, begins a run (IDLE/DONE)
//                core_rst_o/core_run_o core reset / running indication
//                pc_i                  core fetch PC
//                dbg_raddr_o/dbg_rdata_i debug register read (1-cycle latency)
//                exp_addr_i/exp_data_i packed check addresses / expected data
//                done_o, pass_o, timeout_o, fail_idx_o, cycle_count_o results
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_run_controller #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int NUM_CHK     = 2,
    parameter int CYC_W       = 16,
    parameter int MAX_CYCLES  = 200,
    parameter int RST_CYCLES  = 1,
    parameter int HALT_STABLE = 4,
    localparam int FI_W       = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    output logic                      core_rst_o,
    output logic                      core_run_o,
    input  logic [DATA_W-1:0]         pc_i,
    output logic [REG_AW-1:0]         dbg_raddr_o,
    input  logic [DATA_W-1:0]         dbg_rdata_i,
    input  logic [NUM_CHK*REG_AW-1:0] exp_addr_i,
    input  logic [NUM_CHK*DATA_W-1:0] exp_data_i,
    output logic                      done_o,
    output logic                      pass_o,
    output logic                      timeout_o,
    output logic [FI_W-1:0]           fail_idx_o,
    output logic [CYC_W-1:0]          cycle_count_o
);

    // CHECK step counter spans 0..NUM_CHK; the check tables are padded to a
    // power of two so the counter indexes them without width adaptation.
    localparam int CHK_W  = $clog2(NUM_CHK + 1);
    localparam int CHK_N  = 2 ** CHK_W;
    localparam int RC_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int STAB_W = $clog2(HALT_STABLE);

    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(MAX_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(HALT_STABLE - 1);
    localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(RST_CYCLES - 1);
    localparam logic [CHK_W-1:0]  CHK_LAST  = CHK_W'(NUM_CHK);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q;
    logic [RC_W-1:0]     rc_q;
    logic [CYC_W-1:0]    cycle_count_q;
    logic [DATA_W-1:0]   last_pc_q;
    logic [STAB_W-1:0]   stab_q;
    logic [CHK_W-1:0]    chk_q;
    logic                core_rst_q;
    logic                core_run_q;
    logic [REG_AW-1:0]   dbg_raddr_q;
    logic                done_q;
    logic                pass_q;
    logic                timeout_q;
    logic [FI_W-1:0]     fail_idx_q;

    logic [REG_AW-1:0]   chk_addr [CHK_N];
    logic [DATA_W-1:0]   chk_data [CHK_N];

    generate
        for (genvar gi = 0; gi < CHK_N; gi++) begin : g_unpack
            if (gi < NUM_CHK) begin : g_used
                assign chk_addr[gi] = exp_addr_i[gi*REG_AW +: REG_AW];
                assign chk_data[gi] = exp_data_i[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign chk_addr[gi] = '0;
                assign chk_data[gi] = '0;
            end
        end
    endgenerate

    logic [CYC_W-1:0]  cyc_d;
    logic [STAB_W-1:0] stab_d;
    logic [CHK_W-1:0]  chk_d;
    logic [CHK_W-1:0]  cmp_idx;
    logic              halt;
    logic              wdog;
    logic              mismatch;

    always_comb begin
        cyc_d    = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CYC_W'(1);
        stab_d   = (pc_i == last_pc_q) ? stab_q + STAB_W'(1) : '0;
        halt     = (stab_d == STAB_LAST);
        wdog     = (cyc_d == CYC_LAST);
        chk_d    = chk_q + CHK_W'(1);
        // Read data arriving in CHECK step k belongs to the address of step k-1.
        cmp_idx  = chk_q - CHK_W'(1);
        mismatch = (dbg_rdata_i != chk_data[cmp_idx]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            rc_q          <= '0;
            cycle_count_q <= '0;
            last_pc_q     <= '0;
            stab_q        <= '0;
            chk_q         <= '0;
            core_rst_q    <= 1'b1;
            core_run_q    <= 1'b0;
            dbg_raddr_q   <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_idx_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q       <= S_RESET;
                        rc_q          <= '0;
                        core_rst_q    <= 1'b1;
                        done_q        <= 1'b0;
                        pass_q        <= 1'b0;
                        timeout_q     <= 1'b0;
                        fail_idx_q    <= '0;
                        cycle_count_q <= '0;
                    end
                end
                S_RESET: begin
                    last_pc_q <= pc_i;
                    stab_q    <= '0;
                    if (rc_q == RC_LAST) begin
                        state_q    <= S_RUN;
                        core_rst_q <= 1'b0;
                        core_run_q <= 1'b1;
                    end else begin
                        rc_q <= rc_q + RC_W'(1);
                    end
                end
                S_RUN: begin
                    cycle_count_q <= cyc_d;
                    last_pc_q     <= pc_i;
                    stab_q        <= stab_d;
                    // Halt is tested first so a halt on the last watchdog
                    // cycle still gets its registers checked.
                    if (halt) begin
                        state_q     <= S_CHECK;
                        core_run_q  <= 1'b0;
                        chk_q       <= '0;
                        dbg_raddr_q <= chk_addr[0];
                    end else if (wdog) begin
                        state_q    <= S_DONE;
                        core_run_q <= 1'b0;
                        done_q     <= 1'b1;
                        timeout_q  <= 1'b1;
                        pass_q     <= 1'b0;
                    end
                end
                S_CHECK: begin
                    chk_q       <= chk_d;
                    dbg_raddr_q <= chk_addr[chk_d];
                    if (chk_q != '0) begin
                        if (mismatch) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            pass_q      <= 1'b0;
                            fail_idx_q  <= FI_W'(cmp_idx);
                            dbg_raddr_q <= '0;
                        end else if (chk_q == CHK_LAST) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            pass_q      <= 1'b1;
                            dbg_raddr_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    core_rst_q <= 1'b1;
                    core_run_q <= 1'b0;
                end
            endcase
        end
    end

    assign core_rst_o    = core_rst_q;
    assign core_run_o    = core_run_q;
    assign dbg_raddr_o   = dbg_raddr_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign timeout_o     = timeout_q;
    assign fail_idx_o    = fail_idx_q;
    assign cycle_count_o = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_run_controller
//  Description : Directed self-checking bench for riscv_run_controller. A
//                small core model advances the PC by 4 per run cycle until it
//                reaches a chosen halt PC, and serves a register file over
//                the debug port with one cycle of read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_run_controller;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int NUM_CHK = 2;
    localparam int CYC_W = 16;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic                      start_i;
    logic                      core_rst_o;
    logic                      core_run_o;
    logic [DATA_W-1:0]         pc_i;
    logic [REG_AW-1:0]         dbg_raddr_o;
    logic [DATA_W-1:0]         dbg_rdata_i;
    logic [NUM_CHK*REG_AW-1:0] exp_addr_i;
    logic [NUM_CHK*DATA_W-1:0] exp_data_i;
    logic                      done_o;
    logic                      pass_o;
    logic                      timeout_o;
    logic [0:0]                fail_idx_o;
    logic [CYC_W-1:0]          cycle_count_o;

    riscv_run_controller #(
        .DATA_W      (DATA_W),
        .REG_AW      (REG_AW),
        .NUM_CHK     (NUM_CHK),
        .CYC_W       (CYC_W),
        .MAX_CYCLES  (50),
        .RST_CYCLES  (3),
        .HALT_STABLE (4)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .core_rst_o    (core_rst_o),
        .core_run_o    (core_run_o),
        .pc_i          (pc_i),
        .dbg_raddr_o   (dbg_raddr_o),
        .dbg_rdata_i   (dbg_rdata_i),
        .exp_addr_i    (exp_addr_i),
        .exp_data_i    (exp_data_i),
        .done_o        (done_o),
        .pass_o        (pass_o),
        .timeout_o     (timeout_o),
        .fail_idx_o    (fail_idx_o),
        .cycle_count_o (cycle_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Core model
    logic [DATA_W-1:0] regs [32];
    logic [DATA_W-1:0] halt_pc;

    always @(posedge clk_i) begin
        if (core_rst_o)
            pc_i <= '0;
        else if (core_run_o && pc_i != halt_pc)
            pc_i <= pc_i + 32'd4;
        dbg_rdata_i <= regs[dbg_raddr_o];
    end

    int n_chk  = 0;
    int n_pass = 0;
    int rst_hi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Pulse start, optionally poke start during RUN, wait for done.
    task automatic run_prog(input logic [31:0] hpc, input bit poke);
        halt_pc = hpc;
        @(negedge clk_i);
        start_i = 1'b1;
        rst_hi  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            start_i = poke & core_run_o;
            if (core_rst_o) rst_hi++;
            if (done_o) break;
        end
        start_i = 1'b0;
        check("done_seen", done_o, 1);
        check("rst_cycles", rst_hi, 3);
    endtask

    task automatic expect_result(input string tag, input bit ps, input bit to,
                                 input int fi, input int cc);
        check({tag, "_pass"}, pass_o, ps);
        check({tag, "_timeout"}, timeout_o, to);
        check({tag, "_fail_idx"}, fail_idx_o, fi);
        check({tag, "_cycles"}, cycle_count_o, cc);
        check({tag, "_core_run"}, core_run_o, 0);
        check({tag, "_core_rst"}, core_rst_o, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_rst"}, core_rst_o, 1);
        check({tag, "_core_run"}, core_run_o, 0);
        check({tag, "_raddr"}, dbg_raddr_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_pass"}, pass_o, 0);
        check({tag, "_timeout"}, timeout_o, 0);
        check({tag, "_fail_idx"}, fail_idx_o, 0);
        check({tag, "_cycles"}, cycle_count_o, 0);
    endtask

    initial begin
        bit seen_run;
        for (int r = 0; r < 32; r++) regs[r] = '0;
        rst_ni     = 1'b0;
        start_i    = 1'b0;
        halt_pc    = '0;
        exp_addr_i = '0;
        exp_data_i = '0;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_ni = 1'b1;

        // Fibonacci: halts at PC 40, x10=55, x0=0 -> 14 run cycles
        regs[10]   = 32'd55;
        exp_addr_i = {5'd0, 5'd10};
        exp_data_i = {32'd0, 32'd55};
        run_prog(32'd40, 1'b0);
        expect_result("fib", 1, 0, 0, 14);
        repeat (3) @(negedge clk_i);
        check("fib_done_held", done_o, 1);
        check("fib_cycles_held", cycle_count_o, 14);

        // Even/odd counts in x8/x9, halt at PC 28 -> 11 run cycles
        regs[8]    = 32'd4;
        regs[9]    = 32'd4;
        exp_addr_i = {5'd9, 5'd8};
        exp_data_i = {32'd4, 32'd4};
        run_prog(32'd28, 1'b0);
        expect_result("evod", 1, 0, 0, 11);
        exp_data_i = {32'd5, 32'd4};
        run_prog(32'd28, 1'b0);
        expect_result("evod_bad1", 0, 0, 1, 11);
        exp_data_i = {32'd5, 32'd3};
        run_prog(32'd28, 1'b0);
        expect_result("evod_bad01", 0, 0, 0, 11);

        // Never halts: watchdog after 49 run cycles
        exp_addr_i = {5'd0, 5'd10};
        exp_data_i = {32'd0, 32'd55};
        run_prog(32'hFFFF_FFF0, 1'b0);
        expect_result("wdog", 0, 1, 0, 49);

        // Halt lands exactly on the last watchdog cycle, and one cycle later
        run_prog(32'd180, 1'b0);
        expect_result("edge_halt", 1, 0, 0, 49);
        run_prog(32'd184, 1'b0);
        expect_result("edge_late", 0, 1, 0, 49);

        // Reset dropped mid-RUN
        halt_pc = 32'd40;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 20 && !core_run_o; i++) @(negedge clk_i);
        repeat (5) @(negedge clk_i);
        check("midrun_running", core_run_o, 1);
        #1 rst_ni = 1'b0;
        #1 check_reset_outputs("midrun");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset dropped mid-CHECK
        @(negedge clk_i);
        start_i  = 1'b1;
        seen_run = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (core_run_o) seen_run = 1'b1;
            if (seen_run && !core_run_o) break;
        end
        check("midchk_in_check", {done_o, core_rst_o, core_run_o}, 3'b000);
        check("midchk_raddr", dbg_raddr_o, 10);
        #1 rst_ni = 1'b0;
        #1 check_reset_outputs("midchk");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fresh run after abort, then a rerun from DONE with start pokes in RUN
        run_prog(32'd40, 1'b0);
        expect_result("fresh", 1, 0, 0, 14);
        run_prog(32'd40, 1'b1);
        expect_result("poke", 1, 0, 0, 14);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
